// File: rtl/wb_stream_to_mem.sv
// Stream-to-Wishbone write engine: each accepted stream word becomes one classic
// single-beat Wishbone write to consecutive word addresses, ending on count, tlast or error.
//
// state  | meaning
// IDLE   | waiting for cfg_start
// FETCH  | s_tready high, waiting for the next stream word
// WRITE  | single-beat write outstanding, waiting for ack/err/timeout
// DONE   | one-cycle completion pulse
module wb_stream_to_mem #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int SELECT_WIDTH = DATA_WIDTH/8,
  parameter int LEN_WIDTH    = 16,
  parameter int TIMEOUT      = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_start,
  input  logic [ADDR_WIDTH-1:0]   cfg_base_adr,
  input  logic [LEN_WIDTH-1:0]    cfg_len,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic                    s_tlast,
  output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  output logic                    wbm_we_o,
  output logic [SELECT_WIDTH-1:0] wbm_sel_o,
  output logic                    wbm_stb_o,
  output logic                    wbm_cyc_o,
  input  logic                    wbm_ack_i,
  input  logic                    wbm_err_i,
  output logic                    busy,
  output logic                    done,
  output logic                    status_err,
  output logic [LEN_WIDTH-1:0]    words_written
);

  localparam int ALSB = (SELECT_WIDTH > 1) ? $clog2(SELECT_WIDTH) : 0;
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] ADR_MASK = ~ADDR_WIDTH'((1 << ALSB) - 1);
  localparam logic [ADDR_WIDTH-1:0] ADR_STEP = ADDR_WIDTH'(SELECT_WIDTH);
  localparam logic [TW-1:0]         TMR_LOAD = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit                    TMO_EN   = (TIMEOUT > 0);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_WRITE, ST_DONE} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_tready;
  logic                    r_stb;
  logic [SELECT_WIDTH-1:0] r_sel;
  logic [ADDR_WIDTH-1:0]   r_adr;
  logic [DATA_WIDTH-1:0]   r_dat;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;
  logic [LEN_WIDTH-1:0]    r_words;
  logic [LEN_WIDTH-1:0]    r_len;
  logic                    r_last;
  logic [TW-1:0]           r_tmr;

  logic                    w_start;
  logic                    w_accept;
  logic                    w_ack;
  logic                    w_fail;
  logic                    w_tmo;
  logic [LEN_WIDTH-1:0]    w_words_inc;

  assign w_words_inc = r_words + LEN_WIDTH'(1);
  assign w_tmo       = TMO_EN && (r_tmr == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    w_ack       = 1'b0;
    w_fail      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cfg_start) begin
          w_start     = 1'b1;
          w_state_nxt = (cfg_len == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (s_tvalid && r_tready) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // err beats a simultaneous ack; an ack in the final timeout cycle still counts
        if (wbm_err_i || (!wbm_ack_i && w_tmo)) begin
          w_fail      = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (wbm_ack_i) begin
          w_ack       = 1'b1;
          w_state_nxt = ((w_words_inc == r_len) || r_last) ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Control outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tready <= 1'b0;
      r_stb    <= 1'b0;
      r_sel    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_adr    <= '0;
      r_dat    <= '0;
      r_words  <= '0;
      r_len    <= '0;
      r_last   <= 1'b0;
      r_tmr    <= '0;
    end else begin
      r_tready <= (w_state_nxt == ST_FETCH);
      r_stb    <= (w_state_nxt == ST_WRITE);
      r_sel    <= {SELECT_WIDTH{w_state_nxt == ST_WRITE}};
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_done   <= (w_state_nxt == ST_DONE);
      if (w_start) begin
        r_adr   <= cfg_base_adr & ADR_MASK;
        r_words <= '0;
        r_err   <= 1'b0;
        r_len   <= cfg_len;
      end
      if (w_accept) begin
        r_dat  <= s_tdata;
        r_last <= s_tlast;
        r_tmr  <= TMR_LOAD;
      end else if ((r_state == ST_WRITE) && (r_tmr != '0)) begin
        r_tmr  <= r_tmr - TW'(1);
      end
      if (w_ack) begin
        r_words <= w_words_inc;
        r_adr   <= r_adr + ADR_STEP;
      end
      if (w_fail) r_err <= 1'b1;
    end
  end

  assign s_tready      = r_tready;
  assign wbm_adr_o     = r_adr;
  assign wbm_dat_o     = r_dat;
  assign wbm_we_o      = r_stb;
  assign wbm_sel_o     = r_sel;
  assign wbm_stb_o     = r_stb;
  assign wbm_cyc_o     = r_stb;
  assign busy          = r_busy;
  assign done          = r_done;
  assign status_err    = r_err;
  assign words_written = r_words;

endmodule

// File: tb/tb_wb_stream_to_mem.sv
// Bench for wb_stream_to_mem: directed transfers against a registered-ack RAM responder,
// with a transfer-level model of expected writes checked by a per-cycle monitor.
module tb_wb_stream_to_mem;

  typedef struct {logic [15:0] adr; logic [31:0] dat;} wr_t;
  typedef struct {logic [31:0] data; logic last;} sw_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start;
  logic [15:0] cfg_base_adr;
  logic [15:0] cfg_len;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [15:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_stb_o;
  logic        wbm_cyc_o;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic        busy;
  logic        done;
  logic        status_err;
  logic [15:0] words_written;

  int  checks = 0;
  int  fails = 0;
  wr_t exp_q[$];
  sw_t stream_q[$];
  int  exp_ww = 0;
  bit  exp_err = 0;
  int  resp_mode = 0;
  int  err_beat = 0;
  int  resp_beat = 0;
  bit  gap_en = 0;
  int  done_cnt = 0, stb_cycles = 0, last_stb_len = 0, cur_stb_len = 0;
  int  accepted = 0, closed = 0, cyc_n = 0, busy_rise_cyc = 0, done_cyc = 0;

  wb_stream_to_mem #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .LEN_WIDTH(16), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_base_adr(cfg_base_adr), .cfg_len(cfg_len),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .busy(busy), .done(done), .status_err(status_err), .words_written(words_written)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Stream source: pops a word once the handshake has been seen at the previous edge.
  initial begin : stream_drv
    bit hs;
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    forever begin
      @(negedge clk);
      hs = s_tvalid && s_tready;
      @(posedge clk);
      #1;
      if (hs && stream_q.size() > 0) void'(stream_q.pop_front());
      if (stream_q.size() > 0 && (!gap_en || $urandom_range(0, 1) == 1)) begin
        s_tvalid = 1'b1; s_tdata = stream_q[0].data; s_tlast = stream_q[0].last;
      end else begin
        s_tvalid = 1'b0; s_tlast = 1'b0;
      end
    end
  end

  // RAM responder with registered ack; mode 1 never answers, mode 2 adds err on one beat.
  initial begin : responder
    bit req;
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    forever begin
      @(negedge clk);
      req = wbm_stb_o && wbm_cyc_o && !wbm_ack_i && !wbm_err_i;
      @(posedge clk);
      #1;
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
      if (req && resp_mode != 1) begin
        wbm_ack_i = 1'b1;
        if (resp_mode == 2 && resp_beat == err_beat) wbm_err_i = 1'b1;
        resp_beat++;
      end
    end
  end

  initial begin : monitor
    bit  prev_stb, prev_ackb, prev_busy;
    wr_t w;
    prev_stb = 0; prev_ackb = 0; prev_busy = 0;
    repeat (2) @(posedge clk);
    forever begin
      @(negedge clk);
      cyc_n++;
      if (s_tvalid && s_tready) accepted++;
      if (wbm_stb_o) begin
        stb_cycles++;
        cur_stb_len++;
        check("stb_after_ack", prev_ackb, 0);
        check("stb_new_word", accepted - closed, 1);
        check("bus_ctl", {wbm_cyc_o, wbm_we_o, wbm_sel_o}, 6'h3F);
        if (wbm_ack_i && !wbm_err_i) begin
          if (exp_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_write actual=adr %h required=no write", wbm_adr_o);
          end else begin
            w = exp_q.pop_front();
            check("wr_adr", wbm_adr_o, w.adr);
            check("wr_dat", wbm_dat_o, w.dat);
          end
        end
      end else if (prev_stb) begin
        closed++;
        last_stb_len = cur_stb_len;
        cur_stb_len = 0;
      end
      if (busy && !prev_busy) busy_rise_cyc = cyc_n;
      if (done) begin
        done_cnt++;
        done_cyc = cyc_n;
        check("done_ww", words_written, exp_ww);
        check("done_err", status_err, exp_err);
        check("done_pending", exp_q.size(), 0);
      end
      prev_stb  = wbm_stb_o;
      prev_ackb = wbm_stb_o && wbm_ack_i;
      prev_busy = busy;
    end
  end

  // Builds the expected write list from the transfer parameters, then runs the transfer.
  task automatic run_xfer(input logic [15:0] base, input logic [15:0] len, input int n_words,
                          input int last_idx, input logic [31:0] seed, input int mode,
                          input int ebeat, input bit gaps);
    logic [15:0] adr;
    int          d0;
    bit          got;
    wr_t         w;
    sw_t         s;
    exp_q.delete(); exp_ww = 0; exp_err = 0;
    adr = base & 16'hFFFC;
    for (int i = 0; i < n_words && i < int'(len); i++) begin
      if (mode == 1 || (mode == 2 && i == ebeat)) begin
        exp_err = 1;
        break;
      end
      w.adr = adr; w.dat = seed + i;
      exp_q.push_back(w);
      exp_ww++;
      adr = adr + 16'd4;
      if (i == last_idx) break;
    end
    for (int i = 0; i < n_words; i++) begin
      s.data = seed + i; s.last = (i == last_idx);
      stream_q.push_back(s);
    end
    resp_mode = mode; err_beat = ebeat; resp_beat = 0; gap_en = gaps;
    d0 = done_cnt;
    cfg_base_adr = base; cfg_len = len; cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    cfg_len = 16'h0001;
    got = 0;
    for (int c = 0; c < 300 && !got; c++) begin
      tick;
      if (done_cnt != d0) got = 1;
    end
    if (!got) begin
      checks++; fails++;
      $display("FAIL xfer_timeout base=%h actual=no done required=done", base);
    end
    repeat (2) tick;
    check("done_once", done_cnt - d0, 1);
    check("idle_after", busy, 0);
    stream_q.delete();
    gap_en = 0;
    resp_mode = 0;
  endtask

  initial begin : main
    int d0, s0;
    bit got;
    sw_t s;
    cfg_start = 1'b0; cfg_base_adr = '0; cfg_len = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctl", {s_tready, wbm_stb_o, wbm_cyc_o, wbm_we_o, busy, done, status_err}, 0);
    check("rst_adr", wbm_adr_o, 0);
    check("rst_dat", wbm_dat_o, 0);
    check("rst_sel", wbm_sel_o, 0);
    check("rst_ww", words_written, 0);
    tick;
    rst_n = 1'b1;
    tick;

    run_xfer(16'h0100, 16'd4, 4, -1, 32'h0000_00A0, 0, 0, 0);
    check("t1_ww", words_written, 4);
    check("t1_err", status_err, 0);
    check("t1_adr_end", wbm_adr_o, 16'h0110);
    check("t1_cycles", done_cyc - busy_rise_cyc, 12);

    run_xfer(16'h0200, 16'd8, 5, 2, 32'hB000_0000, 0, 0, 0);
    check("t2_ww", words_written, 3);
    check("t2_adr_end", wbm_adr_o, 16'h020C);

    run_xfer(16'hFFF8, 16'd3, 3, -1, 32'hC000_0000, 0, 0, 0);
    check("t3_ww", words_written, 3);
    check("t3_adr_wrap", wbm_adr_o, 16'h0004);

    run_xfer(16'h0303, 16'd5, 5, -1, 32'hD000_0000, 0, 0, 1);
    check("t4_ww", words_written, 5);
    check("t4_adr_end", wbm_adr_o, 16'h0314);

    run_xfer(16'h0400, 16'd2, 2, -1, 32'hE000_0000, 1, 0, 0);
    check("t5_ww", words_written, 0);
    check("t5_err", status_err, 1);
    check("t5_stb_len", last_stb_len, 8);

    run_xfer(16'h0500, 16'd4, 4, -1, 32'hF000_0000, 2, 1, 0);
    check("t6_ww", words_written, 1);
    check("t6_err", status_err, 1);

    s0 = stb_cycles;
    run_xfer(16'h0800, 16'd0, 0, -1, 32'h0, 0, 0, 0);
    check("t7_no_stb", stb_cycles - s0, 0);
    check("t7_cycles", done_cyc - busy_rise_cyc, 0);
    check("t7_err_cleared", status_err, 0);

    exp_q.delete(); exp_ww = 0; exp_err = 0;
    resp_mode = 1;
    for (int i = 0; i < 2; i++) begin
      s.data = 32'h7000_0000 + i; s.last = 1'b0;
      stream_q.push_back(s);
    end
    d0 = done_cnt;
    cfg_base_adr = 16'h0700; cfg_len = 16'd2; cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick;
      if (wbm_stb_o) got = 1;
    end
    if (!got) begin
      checks++; fails++;
      $display("FAIL rst_wait_stb actual=no stb required=stb");
    end
    tick;
    rst_n = 1'b0;
    tick;
    @(negedge clk);
    check("rst_mid_stbcyc", {wbm_stb_o, wbm_cyc_o}, 0);
    check("rst_mid_busy", {busy, done}, 0);
    tick;
    rst_n = 1'b1;
    resp_mode = 0;
    stream_q.delete();
    repeat (3) tick;
    check("rst_no_done", done_cnt - d0, 0);
    check("rst_mid_ww", words_written, 0);
    check("rst_mid_idle", {busy, s_tready}, 0);

    run_xfer(16'h0600, 16'd2, 2, -1, 32'h6000_0000, 0, 0, 0);
    check("t9_ww", words_written, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
